// File: rtl/led_pattern_scheduler.sv
// Playlist controller for the LED pattern engine: generates step_en ticks and
// load pulses while walking a four-entry mode playlist.
module led_pattern_scheduler #(
    parameter int unsigned W_DIV          = 22,
    parameter int unsigned STEPS_PER_MODE = 16,
    parameter logic [7:0]  PLAYLIST       = 8'b11_10_01_00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step_btn,
    input  logic       skip_btn,
    input  logic [1:0] speed,
    output logic       step_en,
    output logic       load,
    output logic [1:0] mode,
    output logic [1:0] entry,
    output logic [7:0] step_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StLoad  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    localparam logic [W_DIV-1:0] DivOne   = 1;
    localparam logic [7:0]       LastStep = 8'(STEPS_PER_MODE - 1);

    state_e           state_q;
    logic [1:0]       entry_q;
    logic [1:0]       mode_q;
    logic [7:0]       step_cnt_q;
    logic [W_DIV-1:0] div_cnt;
    logic             step_en_q;

    logic run_q1, run_q2;
    logic step_q1, step_q2, step_prev;
    logic skip_q1, skip_q2, skip_prev;

    logic             run_s;
    logic             step_edge;
    logic             skip_edge;
    logic [W_DIV-1:0] tap_max;
    logic             div_done;
    logic             last_step;
    logic             tick;
    logic [1:0]       entry_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q1    <= 1'b0;
            run_q2    <= 1'b0;
            step_q1   <= 1'b0;
            step_q2   <= 1'b0;
            step_prev <= 1'b0;
            skip_q1   <= 1'b0;
            skip_q2   <= 1'b0;
            skip_prev <= 1'b0;
        end else begin
            run_q1    <= run;
            run_q2    <= run_q1;
            step_q1   <= step_btn;
            step_q2   <= step_q1;
            step_prev <= step_q2;
            skip_q1   <= skip_btn;
            skip_q2   <= skip_q1;
            skip_prev <= skip_q2;
        end
    end

    assign run_s     = run_q2;
    assign step_edge = step_q2 & ~step_prev;
    assign skip_edge = skip_q2 & ~skip_prev;

    // P-1 = 2^(W_DIV-speed)-1; >= keeps a speed increase from overrunning the count
    assign tap_max   = {W_DIV{1'b1}} >> speed;
    assign div_done  = div_cnt >= tap_max;
    assign last_step = step_cnt_q >= LastStep;
    assign tick      = ((state_q == StRun) && div_done) || ((state_q == StPause) && step_edge);
    assign entry_nxt = entry_q + 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StLoad;
            entry_q    <= 2'd0;
            mode_q     <= PLAYLIST[1:0];
            step_cnt_q <= 8'd0;
            div_cnt    <= '0;
            step_en_q  <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            case (state_q)
                StLoad: begin
                    div_cnt <= '0;
                    state_q <= run_s ? StRun : StPause;
                end
                StRun, StPause: begin
                    if (skip_edge || (tick && last_step)) begin
                        entry_q    <= entry_nxt;
                        mode_q     <= PLAYLIST[{entry_nxt, 1'b0} +: 2];
                        step_cnt_q <= 8'd0;
                        div_cnt    <= '0;
                        state_q    <= StLoad;
                    end else begin
                        if (tick) begin
                            step_en_q  <= 1'b1;
                            step_cnt_q <= step_cnt_q + 8'd1;
                        end
                        if (state_q == StRun) begin
                            // divider holds on the edge that leaves RUN
                            if (div_done) begin
                                div_cnt <= '0;
                            end else if (run_s) begin
                                div_cnt <= div_cnt + DivOne;
                            end
                            if (!run_s) begin
                                state_q <= StPause;
                            end
                        end else if (run_s) begin
                            state_q <= StRun;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign step_en  = step_en_q;
    assign load     = (state_q == StLoad);
    assign mode     = mode_q;
    assign entry    = entry_q;
    assign step_cnt = step_cnt_q;
    assign state    = state_q;

endmodule

// File: doc/led_pattern_scheduler.md
# led_pattern_scheduler

Playlist controller for the 8-bit LED shift-register pattern engine. It generates the engine's `step_en` tick at a selectable rate and drives its 2-bit `mode`. After a fixed number of frames it advances through a 4-entry mode playlist and pulses `load` so the engine re-seeds its pattern. Pause, single-step and skip are controlled from board keys. It sits between `key[]` and the pattern register in the hackathon top.

## Interface
- `W_DIV`, 22: base divider width; tick period is P = 2^(W_DIV−speed) cycles. Legal range 4..31.
- `STEPS_PER_MODE`, 16: frames shown per playlist entry (seed frame included). Legal range 2..255.
- `PLAYLIST`, 8'b11_10_01_00: four 2-bit modes; entry k is `PLAYLIST[2k+1:2k]`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = auto-advance, 0 = paused. Synchronized by 2 flops.
- `step_btn`  in  1  raw level; a rising edge requests one step while paused.
- `skip_btn`  in  1  raw level; a rising edge jumps to the next playlist entry.
- `speed`  in  2  divider tap; 0 is slowest, 3 is fastest. Sampled every cycle, not synchronized.
- `step_en`  out  1  one-cycle pulse; the engine shifts once.
- `load`  out  1  one-cycle pulse; the engine re-seeds (pattern 8'b0000_0001, direction left). When both pulses are high, `load` has priority in the engine.
- `mode`  out  2  current playlist mode.
- `entry`  out  2  current playlist index.
- `step_cnt`  out  8  frames issued in the current entry.
- `state`  out  2  FSM state: LOAD=00, RUN=01, PAUSE=10.

## Operation
- Input conditioning:
  - `step_btn` and `skip_btn` each go through a 2-flop synchronizer plus a previous-value flop.
  - An edge is defined as sync & ~prev.
  - The block does no debouncing; inputs must be bounce-free.
- Reset values:
  - `state`=LOAD, `entry`=0, `mode`=`PLAYLIST[1:0]`, `step_cnt`=0.
  - Divider `div_cnt`=0, `step_en`=0.
  - All synchronizer flops are cleared.
  - `load` = (`state`==LOAD), so `load` is 1 during reset.
- LOAD state:
  - Lasts exactly 1 cycle; `load`=1, `step_en`=0, `div_cnt` cleared.
  - Next state is RUN if synchronized `run`=1, else PAUSE.
  - Button edges arriving in LOAD are discarded.
- RUN state:
  - `div_cnt` increments each cycle.
  - A tick fires when `div_cnt` ≥ P−1. The compare is ≥ so that a speed increase never overruns. On a tick, `div_cnt` returns to 0.
  - Synchronized `run`=0 moves the FSM to PAUSE on the next edge with `div_cnt` held.
  - `step_btn` edges are ignored.
- PAUSE state:
  - `div_cnt` is frozen.
  - A `step_btn` edge counts as one tick.
  - Synchronized `run`=1 returns to RUN, and the divider resumes from its held value.
- Tick accounting:
  - If `step_cnt` < STEPS_PER_MODE−1: `step_en`<=1 for one cycle and `step_cnt`++.
  - Otherwise the tick is replaced by an entry advance: no `step_en`.
- Entry advance (from the last tick or a `skip_btn` edge in RUN/PAUSE):
  - `entry`<=`entry`+1, wrapping 3→0.
  - `mode`<=`PLAYLIST` at the new entry, `step_cnt`<=0, `div_cnt`<=0.
  - Next state is LOAD.
- Priority within one cycle: reset > skip edge > tick > `run` change.
  - A skip edge in the same cycle as a tick suppresses `step_en`.
- Net effect: each entry displays STEPS_PER_MODE frames, i.e. the seed plus STEPS_PER_MODE−1 shifts.

## Timing
- All outputs are registered or a decode of registered `state`; there is no combinational input-to-output path.
- Auto tick: `step_en` is high in the cycle after the edge at which `div_cnt` ≥ P−1 was sampled. The pulse period is P cycles.
- Button latency: the button's effect (`step_en` or `load`) is high starting at the 3rd rising clock edge after the raw input is first sampled high.
  - A held-high button produces exactly one action.
- `run` latency: the state change is visible 3 edges after `run` is first sampled at the new level.
- Entry change: `mode`, `entry` and `load`=1 all appear in the same cycle. The cycle after that, `state` is RUN or PAUSE.
- Reset asserted mid-operation: all reset values hold from the next edge. Any `step_en` pulse in flight is dropped.

## Test plan
Sim configuration: W_DIV=6, STEPS_PER_MODE=4, default PLAYLIST.

- Release reset with `run`=1, `speed`=0 -> `load`=1 for one cycle with `mode`=00, `entry`=0; then `step_en` pulses every 64 cycles.
- Run free for 3 `step_en` pulses -> the 4th tick gives `load`=1, `entry`=1, `mode`=01 and no `step_en`; after entry 3 (`mode`=11), `entry` wraps to 0 and `mode` to 00.
- Drive `run`=0 for 500 cycles -> no `step_en`; then raise `step_btn` and hold it 50 cycles -> exactly one `step_en`, at the 3rd edge, and `step_cnt` increments by 1.
- Align a `skip_btn` edge with an auto tick -> `load`=1, `entry`+1, `step_cnt`=0, no `step_en`; the next tick comes 64 cycles after LOAD.
- Set `speed` 0→3 while `div_cnt`=40 -> a tick on the next cycle, then `step_en` every 8 cycles.
- Assert `reset` one cycle before an expected `step_en` -> no pulse; `state`=LOAD, `entry`=0, `step_cnt`=0, `load`=1.
